ysyx_23060171_regfile_sb: RTL
=============================

# ysyx_23060171_regfile_sb

Parametrised multi-port integer register file with an integrated busy-bit scoreboard, the pipelined successor to the single-write/dual-read GPR.
- Sits between decode (read ports, hazard check, destination issue) and writeback (write ports).
- Any number of read and write ports; x0 hardwired to zero; asynchronous clear of all state.
- Per-register busy bits let decode stall on in-flight destinations; an optional write-to-read bypass is compiled in by macro.

## Interface
Parameters:
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 32, register width
- NR, 2, number of read ports
- NW, 1, number of write ports (1..4)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wen  in  NW  per-port write enable
- waddr  in  NW*ADDR_WIDTH  write index, port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- wdata  in  NW*DATA_WIDTH  write data, packed as waddr
- raddr  in  NR*ADDR_WIDTH  read index, packed per port
- rdata  out  NR*DATA_WIDTH  read data, combinational
- rbusy  out  NR  busy bit of the register addressed by each read port
- iss_valid  in  1  a destination is issued this cycle
- iss_rd  in  ADDR_WIDTH  issued destination index
- flush  in  1  clear all busy bits (pipeline flush)
- busy_cnt  out  ADDR_WIDTH+1  number of registers currently busy

## Operation
- Storage: 2**ADDR_WIDTH x DATA_WIDTH flops; busy vector of 2**ADDR_WIDTH bits.
- Reset (rst_n low, asynchronous): all registers 0, all busy bits 0, busy_cnt 0. rdata reads 0, rbusy 0 while reset is held and after release.
- Write: on posedge, for each k with wen[k]=1 and waddr[k]!=0, reg[waddr[k]] <= wdata[k].
  - Multiple ports writing the same index in one cycle: highest-numbered port wins.
  - Writes to index 0 are discarded; reg[0] is never stored and always reads 0.
- Read: rdata[j] = reg[raddr[j]]; raddr[j]==0 returns 0 regardless of writes.
- Scoreboard, per register i (i != 0), evaluated each posedge:
  - set: iss_valid && iss_rd==i && !flush.
  - clr: any wen[k] && waddr[k]==i, or flush.
  - Next busy: set ? 1 : (clr ? 0 : busy). Issue takes priority over a same-cycle writeback to the same index, because the new producer is younger.
  - Busy bit 0 is constant 0; issue to x0 is ignored.
  - flush clears every busy bit and overrides a same-cycle issue.
- rbusy[j] = busy[raddr[j]] (pre-update value).
- busy_cnt is registered: it equals the population count of the busy vector after each edge and is updated with the busy vector, not separately tracked. Its range is 0..2**ADDR_WIDTH-1.

## Timing
- Write latency: data written at edge N is visible on rdata from the cycle after edge N, without bypass.
- Scoreboard: issue at edge N makes rbusy high from the cycle after N; writeback at edge M clears it from the cycle after M.
- Read paths are purely combinational from raddr and state; no pipeline stage.
- Reset asserted mid-operation clears all state immediately, independent of clk. The first edge after rst_n rises performs normal updates.

## Configuration
- YSYX_23060171_REGFILE_BYPASS_EN defined: if any wen[k] && waddr[k]==raddr[j] && raddr[j]!=0 in the current cycle, rdata[j] returns that wdata[k], using the highest-numbered matching k. rbusy[j] is forced to 0 unless iss_valid && iss_rd==raddr[j] in the same cycle.
- Not defined: rdata and rbusy reflect stored state only, and a same-cycle write is not visible.

## Test plan
- Reset: write 0xDEADBEEF to x5, pulse rst_n low between edges -> rdata for x5 is 0 immediately; busy_cnt=0.
- x0: wen=1, waddr=0, wdata=0xFFFFFFFF; iss_valid with iss_rd=0 -> rdata for x0 is 0, rbusy is 0, busy_cnt=0.
- Write conflict (NW=2): both ports write x7, with 0x11 on port 0 and 0x22 on port 1 -> next cycle x7 reads 0x22.
- Scoreboard:
  - Issue x3 -> rbusy=1 and busy_cnt=1.
  - In the same cycle, writeback x3 and issue x3 -> rbusy stays 1.
  - Writeback x3 alone -> rbusy=0 and busy_cnt=0.
- Flush: issue x1, x2, x4 on successive cycles (busy_cnt=3), then assert flush together with iss_rd=9 -> busy_cnt=0 and x9 is not busy.
- Bypass (macro on): write x10=0x1234 while reading x10 in the same cycle -> rdata=0x1234 that cycle. With the macro off -> rdata shows the old value, and 0x1234 appears the next cycle.

Source files
------------

// File: rtl/ysyx_23060171_regfile_sb.sv
// Multi-port integer register file with a per-register busy scoreboard.
// Optional same-cycle write-to-read bypass when YSYX_23060171_REGFILE_BYPASS_EN is defined.
module ysyx_23060171_regfile_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR         = 2,
    parameter int NW         = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NW-1:0]            wen,
    input  logic [NW*ADDR_WIDTH-1:0] waddr,
    input  logic [NW*DATA_WIDTH-1:0] wdata,
    input  logic [NR*ADDR_WIDTH-1:0] raddr,
    output logic [NR*DATA_WIDTH-1:0] rdata,
    output logic [NR-1:0]            rbusy,
    input  logic                     iss_valid,
    input  logic [ADDR_WIDTH-1:0]    iss_rd,
    input  logic                     flush,
    output logic [ADDR_WIDTH:0]      busy_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]      r_busy;
    logic [DEPTH-1:0]      w_busyNext;
    logic [ADDR_WIDTH:0]   r_busyCnt;
    logic [ADDR_WIDTH:0]   w_busyCntNext;
    logic [ADDR_WIDTH-1:0] w_waddr [NW];
    logic [DATA_WIDTH-1:0] w_wdata [NW];
    logic [ADDR_WIDTH-1:0] w_raddr [NR];

    for (genvar k = 0; k < NW; k++) begin : g_wport
        assign w_waddr[k] = waddr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata[k] = wdata[k*DATA_WIDTH +: DATA_WIDTH];
    end

    for (genvar j = 0; j < NR; j++) begin : g_rport
        assign w_raddr[j] = raddr[j*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Later ports are applied last, so the highest-numbered writer wins a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (wen[k] && (w_waddr[k] != '0)) begin
                    r_regs[w_waddr[k]] <= w_wdata[k];
                end
            end
        end
    end

    // Issue overrides a same-cycle writeback (younger producer); flush overrides issue.
    always_comb begin
        w_busyNext = r_busy;
        for (int k = 0; k < NW; k++) begin
            if (wen[k]) begin
                w_busyNext[w_waddr[k]] = 1'b0;
            end
        end
        if (flush) begin
            w_busyNext = '0;
        end else if (iss_valid) begin
            w_busyNext[iss_rd] = 1'b1;
        end
        w_busyNext[0] = 1'b0;

        w_busyCntNext = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_busyCntNext = w_busyCntNext + {{ADDR_WIDTH{1'b0}}, w_busyNext[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy    <= '0;
            r_busyCnt <= '0;
        end else begin
            r_busy    <= w_busyNext;
            r_busyCnt <= w_busyCntNext;
        end
    end

    assign busy_cnt = r_busyCnt;

    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int j = 0; j < NR; j++) begin
            if (w_raddr[j] != '0) begin
                rdata[j*DATA_WIDTH +: DATA_WIDTH] = r_regs[w_raddr[j]];
            end
            rbusy[j] = r_busy[w_raddr[j]];
`ifdef YSYX_23060171_REGFILE_BYPASS_EN
            for (int k = 0; k < NW; k++) begin
                if (rst_n && wen[k] && (w_waddr[k] == w_raddr[j]) && (w_raddr[j] != '0)) begin
                    rdata[j*DATA_WIDTH +: DATA_WIDTH] = w_wdata[k];
                    rbusy[j] = (iss_valid && (iss_rd == w_raddr[j])) ? r_busy[w_raddr[j]] : 1'b0;
                end
            end
`endif
        end
    end

endmodule
